// File: rtl/syncgen_prog.sv
// Programmable display timing generator: counters, syncs, DE/preDE, read-start and frame pulses.
// Optional macro SYNCGEN_PROG_POL_EN enables run-time sync polarity (HPOL/VPOL); otherwise syncs are active-low.
module syncgen_prog #(
    parameter int unsigned CNT_W    = 11,
    parameter int unsigned PRE_LEAD = 3
) (
    input  logic             DCLK,
    input  logic             DRST,
    input  logic [CNT_W-1:0] HFP,
    input  logic [CNT_W-1:0] HPW,
    input  logic [CNT_W-1:0] HBP,
    input  logic [CNT_W-1:0] HTOT,
    input  logic [CNT_W-1:0] VFP,
    input  logic [CNT_W-1:0] VPW,
    input  logic [CNT_W-1:0] VBP,
    input  logic [CNT_W-1:0] VTOT,
    input  logic             HPOL,
    input  logic             VPOL,
    output logic [CNT_W-1:0] HCNT,
    output logic [CNT_W-1:0] VCNT,
    output logic             DSP_HSYNC_X,
    output logic             DSP_VSYNC_X,
    output logic             DSP_DE,
    output logic             DSP_preDE,
    output logic             VRSTART,
    output logic             FRAME_START,
    output logic             CFG_ERR
);

    localparam int unsigned W2 = CNT_W + 2;

    typedef logic [W2-1:0] wide_t;

    typedef struct packed {
        logic [CNT_W-1:0] hfp;
        logic [CNT_W-1:0] hpw;
        logic [CNT_W-1:0] hbp;
        logic [CNT_W-1:0] htot;
        logic [CNT_W-1:0] vfp;
        logic [CNT_W-1:0] vpw;
        logic [CNT_W-1:0] vbp;
        logic [CNT_W-1:0] vtot;
    } timing_t;

    function automatic wide_t wide(input logic [CNT_W-1:0] x);
        return {2'b00, x};
    endfunction

    timing_t          tim_in;
    timing_t          shadow_q, shadow_d;
    logic             cfg_err_q, cfg_err_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d;
    logic [CNT_W-1:0] vcnt_q, vcnt_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             de_q, de_d;
    logic             pre_de_q, pre_de_d;
    logic             vrstart_q, vrstart_d;
    logic             frame_start_q, frame_start_d;

    logic             hpol_rst, vpol_rst;
    logic             hpol_act, vpol_act;

    wide_t            hstart_in, vstart_in;
    logic             in_legal;
    logic             h_last, v_last, load_pt;

    wide_t            hstart, vstart;
    wide_t            hpos, vpos, pre_pos, vnext;
    logic             hs_win, vs_win, v_active;

    assign tim_in = '{hfp: HFP, hpw: HPW, hbp: HBP, htot: HTOT,
                      vfp: VFP, vpw: VPW, vbp: VBP, vtot: VTOT};

`ifdef SYNCGEN_PROG_POL_EN
    logic hpol_q, hpol_d;
    logic vpol_q, vpol_d;

    always_comb begin
        hpol_d = hpol_q;
        vpol_d = vpol_q;
        if (load_pt && in_legal) begin
            hpol_d = HPOL;
            vpol_d = VPOL;
        end
    end

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            hpol_q <= HPOL;
            vpol_q <= VPOL;
        end else begin
            hpol_q <= hpol_d;
            vpol_q <= vpol_d;
        end
    end

    assign hpol_act = hpol_d;
    assign vpol_act = vpol_d;
    assign hpol_rst = HPOL;
    assign vpol_rst = VPOL;
`else
    logic unused_pol;
    assign unused_pol = HPOL ^ VPOL;
    assign hpol_act   = 1'b0;
    assign vpol_act   = 1'b0;
    assign hpol_rst   = 1'b0;
    assign vpol_rst   = 1'b0;
`endif

    // Legality of the live inputs; evaluated in extended width so porch sums cannot wrap.
    always_comb begin
        hstart_in = wide(HFP) + wide(HPW) + wide(HBP);
        vstart_in = wide(VFP) + wide(VPW) + wide(VBP);
        in_legal  = (HFP != '0) && (HPW != '0) && (HBP != '0) &&
                    (VFP != '0) && (VPW != '0) && (VBP != '0) &&
                    (hstart_in < wide(HTOT)) && (vstart_in < wide(VTOT)) &&
                    (hstart_in >= wide_t'(PRE_LEAD));
    end

    // Counters and shadow update; ">=" keeps the counters bounded even after an illegal reset load.
    always_comb begin
        h_last    = (wide(hcnt_q) + wide_t'(1)) >= wide(shadow_q.htot);
        v_last    = (wide(vcnt_q) + wide_t'(1)) >= wide(shadow_q.vtot);
        load_pt   = h_last && v_last;
        shadow_d  = shadow_q;
        cfg_err_d = cfg_err_q;
        hcnt_d    = hcnt_q + CNT_W'(1);
        vcnt_d    = vcnt_q;
        if (load_pt) begin
            cfg_err_d = ~in_legal;
            if (in_legal) begin
                shadow_d = tim_in;
            end
        end
        if (h_last) begin
            hcnt_d = '0;
            vcnt_d = v_last ? '0 : (vcnt_q + CNT_W'(1));
        end
    end

    // Outputs are decoded from the next position and next shadow so they register aligned with HCNT/VCNT.
    always_comb begin
        hstart    = wide(shadow_d.hfp) + wide(shadow_d.hpw) + wide(shadow_d.hbp);
        vstart    = wide(shadow_d.vfp) + wide(shadow_d.vpw) + wide(shadow_d.vbp);
        hpos      = wide(hcnt_d);
        vpos      = wide(vcnt_d);
        pre_pos   = hpos + wide_t'(PRE_LEAD);
        vnext     = vpos + wide_t'(1);
        hs_win    = (hpos >= wide(shadow_d.hfp)) &&
                    (hpos < (wide(shadow_d.hfp) + wide(shadow_d.hpw)));
        vs_win    = (vpos >= wide(shadow_d.vfp)) &&
                    (vpos < (wide(shadow_d.vfp) + wide(shadow_d.vpw)));
        v_active  = (vpos >= vstart) && (vpos < wide(shadow_d.vtot));
        de_d      = v_active && (hpos >= hstart) && (hpos < wide(shadow_d.htot));
        pre_de_d  = v_active && (pre_pos >= hstart) && (pre_pos < wide(shadow_d.htot));
        vrstart_d = (hcnt_d == CNT_W'(1)) && (vnext >= vstart) &&
                    (vnext < wide(shadow_d.vtot));
        frame_start_d = (hcnt_d == '0) && (vcnt_d == '0);
        hsync_d   = ~(hs_win ^ hpol_act);
        vsync_d   = ~(vs_win ^ vpol_act);
    end

    always_ff @(posedge DCLK) begin
        if (DRST) begin
            shadow_q      <= tim_in;
            cfg_err_q     <= ~in_legal;
            hcnt_q        <= '0;
            vcnt_q        <= '0;
            hsync_q       <= ~hpol_rst;
            vsync_q       <= ~vpol_rst;
            de_q          <= 1'b0;
            pre_de_q      <= 1'b0;
            vrstart_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            shadow_q      <= shadow_d;
            cfg_err_q     <= cfg_err_d;
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            de_q          <= de_d;
            pre_de_q      <= pre_de_d;
            vrstart_q     <= vrstart_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign HCNT        = hcnt_q;
    assign VCNT        = vcnt_q;
    assign DSP_HSYNC_X = hsync_q;
    assign DSP_VSYNC_X = vsync_q;
    assign DSP_DE      = de_q;
    assign DSP_preDE   = pre_de_q;
    assign VRSTART     = vrstart_q;
    assign FRAME_START = frame_start_q;
    assign CFG_ERR     = cfg_err_q;

endmodule

// File: tb/tb_syncgen_prog.sv
// Bench for syncgen_prog: position-based reference model checked every cycle plus directed literal checks.
module tb_syncgen_prog;

    localparam int CNT_W    = 11;
    localparam int PRE_LEAD = 3;
`ifdef SYNCGEN_PROG_POL_EN
    localparam int POL_EN = 1;
`else
    localparam int POL_EN = 0;
`endif

    logic             DCLK = 1'b0;
    logic             DRST;
    logic [CNT_W-1:0] HFP, HPW, HBP, HTOT, VFP, VPW, VBP, VTOT;
    logic             HPOL, VPOL;
    logic [CNT_W-1:0] HCNT, VCNT;
    logic             DSP_HSYNC_X, DSP_VSYNC_X, DSP_DE, DSP_preDE;
    logic             VRSTART, FRAME_START, CFG_ERR;

    syncgen_prog #(.CNT_W(CNT_W), .PRE_LEAD(PRE_LEAD)) dut (
        .DCLK(DCLK), .DRST(DRST),
        .HFP(HFP), .HPW(HPW), .HBP(HBP), .HTOT(HTOT),
        .VFP(VFP), .VPW(VPW), .VBP(VBP), .VTOT(VTOT),
        .HPOL(HPOL), .VPOL(VPOL),
        .HCNT(HCNT), .VCNT(VCNT),
        .DSP_HSYNC_X(DSP_HSYNC_X), .DSP_VSYNC_X(DSP_VSYNC_X),
        .DSP_DE(DSP_DE), .DSP_preDE(DSP_preDE),
        .VRSTART(VRSTART), .FRAME_START(FRAME_START), .CFG_ERR(CFG_ERR)
    );

    always #5 DCLK = ~DCLK;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks position and the timing set in force.
    int m_h, m_v, m_hfp, m_hpw, m_hbp, m_htot, m_vfp, m_vpw, m_vbp, m_vtot;
    bit m_hpol, m_vpol, m_err, m_rst;
    bit m_valid = 1'b0;

    function automatic bit inputs_legal();
        int hs, vs;
        hs = int'(HFP) + int'(HPW) + int'(HBP);
        vs = int'(VFP) + int'(VPW) + int'(VBP);
        return HFP > 0 && HPW > 0 && HBP > 0 && VFP > 0 && VPW > 0 && VBP > 0 &&
               hs < int'(HTOT) && vs < int'(VTOT) && hs >= PRE_LEAD;
    endfunction

    task automatic model_load();
        m_hfp = HFP; m_hpw = HPW; m_hbp = HBP; m_htot = HTOT;
        m_vfp = VFP; m_vpw = VPW; m_vbp = VBP; m_vtot = VTOT;
        m_hpol = HPOL; m_vpol = VPOL;
    endtask

    always @(posedge DCLK) begin
        bit lg, lp;
        lg = inputs_legal();
        if (DRST) begin
            m_h = 0; m_v = 0;
            model_load();
            m_err = !lg; m_rst = 1'b1; m_valid = 1'b1;
        end else if (m_valid) begin
            lp = (m_h == m_htot - 1) && (m_v == m_vtot - 1);
            m_rst = 1'b0;
            m_h++;
            if (m_h >= m_htot) begin
                m_h = 0;
                m_v++;
                if (m_v >= m_vtot) m_v = 0;
            end
            if (lp) begin
                if (lg) model_load();
                m_err = !lg;
            end
        end
    end

    always @(negedge DCLK) begin
        if (m_valid) begin
            int hstart, vstart;
            bit hs, vs, vact, de, pre, vr, fs;
            hstart = m_hfp + m_hpw + m_hbp;
            vstart = m_vfp + m_vpw + m_vbp;
            hs   = m_h >= m_hfp && m_h < m_hfp + m_hpw;
            vs   = m_v >= m_vfp && m_v < m_vfp + m_vpw;
            vact = m_v >= vstart && m_v < m_vtot;
            de   = vact && m_h >= hstart && m_h < m_htot;
            pre  = vact && m_h >= hstart - PRE_LEAD && m_h <= m_htot - 1 - PRE_LEAD;
            vr   = m_h == 1 && m_v >= vstart - 1 && m_v <= m_vtot - 2;
            fs   = m_h == 0 && m_v == 0;
            if (m_rst) begin
                hs = 0; vs = 0; de = 0; pre = 0; vr = 0; fs = 0;
            end
            if (POL_EN != 0) begin
                hs = m_hpol ? hs : !hs;
                vs = m_vpol ? vs : !vs;
            end else begin
                hs = !hs;
                vs = !vs;
            end
            chk("model_HCNT", int'(HCNT), m_h);
            chk("model_VCNT", int'(VCNT), m_v);
            chk("model_HSYNC_X", int'(DSP_HSYNC_X), int'(hs));
            chk("model_VSYNC_X", int'(DSP_VSYNC_X), int'(vs));
            chk("model_DE", int'(DSP_DE), int'(de));
            chk("model_preDE", int'(DSP_preDE), int'(pre));
            chk("model_VRSTART", int'(VRSTART), int'(vr));
            chk("model_FRAME_START", int'(FRAME_START), int'(fs));
            chk("model_CFG_ERR", int'(CFG_ERR), int'(m_err));
        end
    end

    task automatic step();
        @(negedge DCLK);
    endtask

    // Advances at least one cycle, then until the given position (bounded).
    task automatic goto(input int h, input int v);
        int n;
        n = 0;
        do begin
            @(negedge DCLK);
            n++;
        end while (!(int'(HCNT) == h && int'(VCNT) == v) && n < 500);
        chk($sformatf("reach_%0d_%0d", h, v), int'(int'(HCNT) == h && int'(VCNT) == v), 1);
    endtask

    // sig: 0 hsync, 1 vsync, 2 de, 3 preDE, 4 vrstart
    task automatic pt(input int h, input int v, input int sig, input int exp);
        int act;
        goto(h, v);
        case (sig)
            0:       act = DSP_HSYNC_X;
            1:       act = DSP_VSYNC_X;
            2:       act = DSP_DE;
            3:       act = DSP_preDE;
            default: act = VRSTART;
        endcase
        chk($sformatf("pt_sig%0d_%0d_%0d", sig, h, v), act, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fs_cnt, fs_last, vs_low;
        DRST = 1'b1;
        HFP = 11'd2; HPW = 11'd3; HBP = 11'd4; HTOT = 11'd16;
        VFP = 11'd1; VPW = 11'd2; VBP = 11'd2; VTOT = 11'd8;
        HPOL = 1'b0; VPOL = 1'b0;
        repeat (2) step();
        DRST = 1'b0;

        chk("rst_HCNT", int'(HCNT), 0);
        chk("rst_VCNT", int'(VCNT), 0);
        chk("rst_FRAME_START", int'(FRAME_START), 0);
        chk("rst_DE", int'(DSP_DE), 0);
        chk("rst_HSYNC_X", int'(DSP_HSYNC_X), 1);
        chk("rst_VSYNC_X", int'(DSP_VSYNC_X), 1);
        chk("rst_CFG_ERR", int'(CFG_ERR), 0);

        pt(2, 0, 0, 0);  pt(4, 0, 0, 0);  pt(5, 0, 0, 1);
        pt(0, 1, 1, 0);  pt(15, 2, 1, 0); pt(0, 3, 1, 1);
        pt(1, 3, 4, 0);  pt(1, 4, 4, 1);
        pt(5, 5, 3, 0);  pt(6, 5, 3, 1);  pt(8, 5, 2, 0);  pt(9, 5, 2, 1);
        pt(12, 5, 3, 1); pt(13, 5, 3, 0);
        pt(1, 6, 4, 1);  pt(1, 7, 4, 0);  pt(15, 7, 2, 1);

        goto(0, 0);
        chk("fs_first_frame", int'(FRAME_START), 1);
        fs_cnt = 0; fs_last = -1; vs_low = 0;
        for (int i = 0; i < 384; i++) begin
            if (FRAME_START) begin
                fs_cnt++;
                if (fs_last >= 0) chk("fs_spacing", i - fs_last, 128);
                fs_last = i;
            end
            if (!DSP_VSYNC_X) vs_low++;
            step();
        end
        chk("fs_count_3frames", fs_cnt, 3);
        chk("vsync_low_cycles", vs_low, 96);

        goto(3, 2);
        HTOT = 11'd20;
        goto(15, 2);
        step();
        chk("old_line_HCNT", int'(HCNT), 0);
        chk("old_line_VCNT", int'(VCNT), 3);
        goto(15, 7);
        step();
        chk("load_HCNT", int'(HCNT), 0);
        chk("load_VCNT", int'(VCNT), 0);
        goto(19, 0);
        step();
        chk("new_line_HCNT", int'(HCNT), 0);
        chk("new_line_VCNT", int'(VCNT), 1);

        HTOT = 11'd16;
        goto(0, 0);
        goto(0, 2);
        HBP = 11'd0;
        goto(0, 0);
        chk("illegal_CFG_ERR", int'(CFG_ERR), 1);
        pt(8, 5, 2, 0);
        pt(9, 5, 2, 1);
        HBP = 11'd4;
        goto(0, 6);
        chk("err_held_CFG_ERR", int'(CFG_ERR), 1);
        goto(0, 0);
        chk("restored_CFG_ERR", int'(CFG_ERR), 0);

        goto(0, 2);
        HPOL = 1'b1;
        goto(0, 0);
        pt(2, 0, 0, POL_EN);
        pt(5, 0, 0, 1 - POL_EN);

        goto(7, 6);
        DRST = 1'b1;
        step();
        DRST = 1'b0;
        chk("drst_HCNT", int'(HCNT), 0);
        chk("drst_VCNT", int'(VCNT), 0);
        chk("drst_DE", int'(DSP_DE), 0);
        chk("drst_HSYNC_X", int'(DSP_HSYNC_X), 1 - POL_EN);
        chk("drst_VSYNC_X", int'(DSP_VSYNC_X), 1);
        chk("drst_FRAME_START", int'(FRAME_START), 0);
        goto(0, 0);
        chk("drst_next_fs", int'(FRAME_START), 1);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/syncgen_prog.md
# syncgen_prog

Programmable display timing generator: the parametrised successor of the fixed-mode sync generator. It produces horizontal/vertical counters, sync strobes, data-enable, pre-data-enable and line-buffer read-start pulses from run-time timing inputs instead of a compiled resolution table. New timing is shadow-loaded only at frame boundaries, and illegal settings are flagged. It sits between the register block (timing source) and the pixel pipeline/display output stage.

## Interface
- CNT_W, 11: width of all counters and timing inputs.
- PRE_LEAD, 3: cycles by which DSP_preDE leads DSP_DE.
- DCLK  in  1  pixel clock; single clock domain.
- DRST  in  1  reset; synchronous, active-high.
- HFP, HPW, HBP, HTOT  in  CNT_W each  horizontal front porch, sync width, back porch, total line length (pixels).
- VFP, VPW, VBP, VTOT  in  CNT_W each  vertical equivalents (lines).
- HPOL, VPOL  in  1 each  sync polarity, 1 = active-high (see Configuration).
- HCNT, VCNT  out  CNT_W each  current pixel/line position.
- DSP_HSYNC_X, DSP_VSYNC_X  out  1 each  sync strobes.
- DSP_DE  out  1  active-pixel enable.
- DSP_preDE  out  1  DE advanced by PRE_LEAD cycles.
- VRSTART  out  1  one-cycle line-buffer read-start pulse.
- FRAME_START  out  1  one-cycle pulse at HCNT=0, VCNT=0.
- CFG_ERR  out  1  sticky-until-next-check illegal-timing flag.

## Operation
- Derived: HSTART = HFP+HPW+HBP, VSTART = VFP+VPW+VBP, computed at CNT_W+2 bits (no wrap).
- Shadow registers hold all eight timing values plus polarity; every output uses only the shadows.
- Legality check on inputs: all of HFP,HPW,HBP,VFP,VPW,VBP ≥ 1; HSTART < HTOT; VSTART < VTOT; HSTART ≥ PRE_LEAD.
- Load point: cycle where HCNT=HTOT−1 and VCNT=VTOT−1 (shadow values). Legal inputs → shadows updated, CFG_ERR←0. Illegal → shadows kept, CFG_ERR←1.
- During DRST: shadows load inputs unconditionally; CFG_ERR←legality result.
- HCNT: 0..HTOT−1, wraps to 0. VCNT increments when HCNT wraps; 0..VTOT−1, wraps to 0.
- All outputs registered and aligned to HCNT/VCNT of the same cycle:
  - HSYNC active while HCNT ∈ [HFP, HFP+HPW−1]; VSYNC active while VCNT ∈ [VFP, VFP+VPW−1] (whole lines).
  - DSP_DE = HCNT ∈ [HSTART, HTOT−1] and VCNT ∈ [VSTART, VTOT−1].
  - DSP_preDE = HCNT ∈ [HSTART−PRE_LEAD, HTOT−1−PRE_LEAD] on the same active lines.
  - VRSTART = 1 when HCNT=1 and VCNT ∈ [VSTART−1, VTOT−2] (one line before each active line).
  - FRAME_START = 1 when HCNT=0 and VCNT=0.

## Timing
- Reset values: HCNT=0, VCNT=0, syncs inactive (per loaded polarity), DSP_DE=0, DSP_preDE=0, VRSTART=0, FRAME_START=0 on first cycle after reset (then 1 only per rule above; FRAME_START is 1 on the cycle HCNT=0,VCNT=0 following reset).
- New timing takes effect on the cycle HCNT=0, VCNT=0 after the load point; no partial frame ever mixes timings.
- Input changes mid-frame: ignored until load point; only the values present at the load point count.
- DRST mid-frame: next cycle counters at 0 and outputs at reset values regardless of position.
- Timing inputs are quasi-static; no synchroniser.

## Configuration
- SYNCGEN_PROG_POL_EN defined: HPOL/VPOL shadow-loaded with timing; sync output = active level when in sync window, else inverse.
- Undefined: HPOL/VPOL ignored; both syncs fixed active-low (idle 1).

## Test plan
- Reset with HFP=2,HPW=3,HBP=4,HTOT=16, VFP=1,VPW=2,VBP=2,VTOT=8 -> HCNT cycles 0..15; HSYNC_X low at HCNT 2..4; DE high HCNT 9..15 on VCNT 5..7; preDE high HCNT 6..12 on those lines; VRSTART at HCNT=1 on VCNT 4,5,6.
- Same timing, run 3 frames -> FRAME_START exactly once per 128 cycles; VSYNC_X low for all of VCNT 1..2.
- Change HTOT to 20 mid-frame -> current frame keeps 16-pixel lines; first line after load point is 20 pixels.
- Set HBP=0 mid-frame -> at load point CFG_ERR=1, timing unchanged; restore HBP=4 -> CFG_ERR=0 after next load point.
- Assert DRST for 1 cycle at HCNT=7, VCNT=6 -> next cycle HCNT=0, VCNT=0, DE=0, syncs inactive.
- With SYNCGEN_PROG_POL_EN, HPOL=1 -> HSYNC_X high at HCNT 2..4, low elsewhere; without macro, same stimulus -> low at 2..4.
